// File: rtl/msrv32_pkg.sv
// Shared MSRV32 core definitions used by the PC register, PC mux and fetch logic.
package msrv32_pkg;

    // Native register and address width of the RV32I core.
    localparam int unsigned XLEN = 32;

    // Address the core starts fetching from when reset is released.
    localparam logic [XLEN-1:0] BOOT_ADDRESS = 32'h0000_0000;

endpackage : msrv32_pkg

// File: rtl/msrv32_reg_block_1.sv
// Program-counter register (pipeline stage 1) of the MSRV32 core.
// Captures the PC mux output every rising clock edge and presents it as the
// current PC. Reset forces the boot address immediately and holds it there.
// There is no enable: stalls are made upstream by re-driving the current PC.
// All bits are stored verbatim; alignment is checked elsewhere.
module msrv32_reg_block_1
    import msrv32_pkg::*;
#(
    parameter int unsigned      WIDTH        = XLEN,
    parameter logic [WIDTH-1:0] BOOT_ADDRESS = msrv32_pkg::BOOT_ADDRESS
) (
    input  logic [WIDTH-1:0] pc_mux_in,
    input  logic             ms_risc32_mp_clk_in,
    input  logic             ms_risc32_mp_rst_in,
    output logic [WIDTH-1:0] pc_out
);

    logic [WIDTH-1:0] pc_r;

    // PC state: async load of the boot address while reset is low, else capture next PC.
    always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_in) begin
        if (!ms_risc32_mp_rst_in) begin
            pc_r <= BOOT_ADDRESS;
        end else begin
            pc_r <= pc_mux_in;
        end
    end

    // Output is driven straight from the flop; no path from pc_mux_in.
    assign pc_out = pc_r;

endmodule : msrv32_reg_block_1

// File: tb/tb_msrv32_reg_block_1.sv
// Bench for the MSRV32 PC register: directed stimulus pushes hand-computed
// expected PC values into a queue; a monitor pops and compares them.
module tb_msrv32_reg_block_1;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } chk_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_mux_in;
    logic [31:0] pc_out;

    chk_t        sb_q[$];
    event        sample_ev;
    int          n_checks;
    int          n_errors;

    msrv32_reg_block_1 dut (
        .pc_mux_in          (pc_mux_in),
        .ms_risc32_mp_clk_in(clk),
        .ms_risc32_mp_rst_in(rst_n),
        .pc_out             (pc_out)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue one expectation and wake the monitor.
    task automatic expect_pc(input string name, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.exp  = exp;
        sb_q.push_back(c);
        -> sample_ev;
    endtask

    // Monitor: compare the current pc_out against every queued expectation.
    initial begin
        chk_t c;
        forever begin
            @(sample_ev);
            while (sb_q.size() != 0) begin
                c = sb_q.pop_front();
                n_checks++;
                if (pc_out !== c.exp) begin
                    n_errors++;
                    $display("FAIL %s: pc_out=%08h expected=%08h at %0t", c.name, pc_out, c.exp, $time);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int wait_cycles;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        pc_mux_in = 32'h1234_5678;

        // Power-up reset: edges ignored while reset is low.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            expect_pc("por_hold", 32'h0000_0000);
        end

        // Release between edges; first capture on the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1 expect_pc("release_pre_edge", 32'h0000_0000);
        @(posedge clk); #1;
        expect_pc("release_capture", 32'h1234_5678);
        @(posedge clk); #1;
        expect_pc("release_stable", 32'h1234_5678);

        // Asynchronous assert mid-cycle with clock low.
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1 expect_pc("async_assert", 32'h0000_0000);

        // Re-release and track successive values with one-cycle latency.
        @(negedge clk);
        rst_n     = 1'b1;
        pc_mux_in = 32'h0000_0004;
        @(posedge clk); #1;
        expect_pc("track_4", 32'h0000_0004);
        @(negedge clk);
        pc_mux_in = 32'h0000_0008;
        #1 expect_pc("track_8_pre_edge", 32'h0000_0004);
        @(posedge clk); #1;
        expect_pc("track_8", 32'h0000_0008);
        @(negedge clk);
        pc_mux_in = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        expect_pc("track_fffffffc", 32'hFFFF_FFFC);

        // Between-edge glitch on pc_mux_in has no effect until the edge.
        @(negedge clk);
        pc_mux_in = 32'hAAAA_AAAA;
        #1 expect_pc("glitch_a", 32'hFFFF_FFFC);
        pc_mux_in = 32'h5555_5555;
        #1 expect_pc("glitch_5", 32'hFFFF_FFFC);
        pc_mux_in = 32'hAAAA_AAAA;
        #1 expect_pc("glitch_back", 32'hFFFF_FFFC);
        @(posedge clk); #1;
        expect_pc("glitch_capture", 32'hAAAA_AAAA);

        // Unaligned value stored verbatim.
        @(negedge clk);
        pc_mux_in = 32'h0000_0003;
        @(posedge clk); #1;
        expect_pc("unaligned", 32'h0000_0003);

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 10) begin
            @(negedge clk);
            -> sample_ev;
            wait_cycles++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_msrv32_reg_block_1
